// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit byte arbiter.
package uart_arb_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam logic [7:0]  NEWLINE            = 8'h0A;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/axis_out_reg.sv
// One-entry AXI-stream output register with a load/accept handshake.
// acc_c tells the arbiter a byte can be loaded this cycle.
module axis_out_reg
  import uart_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = uart_arb_pkg::DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  acc_c,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready
);

  out_state_t            state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  // State and data register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OUT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  // Next state: fill when empty, refill or drain when the consumer takes the byte
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    unique case (state_q)
      OUT_EMPTY: begin
        if (load) begin
          state_d = OUT_FULL;
          data_d  = load_data;
        end
      end
      OUT_FULL: begin
        if (m_axis_tready) begin
          if (load) begin
            data_d = load_data;
          end else begin
            state_d = OUT_EMPTY;
          end
        end
      end
      default: state_d = OUT_EMPTY;
    endcase
  end

  assign acc_c         = (state_q == OUT_EMPTY) | m_axis_tready;
  assign m_axis_tdata  = data_q;
  assign m_axis_tvalid = (state_q == OUT_FULL);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the UART transmit stream between the console
// (s0) and the vt52 keyboard path (s1). Optional line locking is enabled
// with the UART_ARB_LINE_LOCK_EN macro.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = uart_arb_pkg::DEFAULT_DATA_WIDTH,
  parameter int unsigned LOCK_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
  input  logic                  s0_axis_tvalid,
  output logic                  s0_axis_tready,
  input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
  input  logic                  s1_axis_tvalid,
  output logic                  s1_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  lock_active,
  output logic                  lock_owner
);

  logic                  acc_c;
  logic                  winner_c;
  logic                  xfer0_c, xfer1_c, load_c;
  logic [DATA_WIDTH-1:0] load_data_c;
  logic                  lock_held_c, lock_own_c;
  logic                  last_served_q, last_served_d;

  // Pick the source granted this cycle
  always_comb begin
    winner_c = 1'b0;
    if (lock_held_c) begin
      winner_c = lock_own_c;
    end else if (s0_axis_tvalid & s1_axis_tvalid) begin
      winner_c = ~last_served_q;
    end else if (s1_axis_tvalid) begin
      winner_c = 1'b1;
    end
  end

  assign s0_axis_tready = ~winner_c & acc_c;
  assign s1_axis_tready =  winner_c & acc_c;
  assign xfer0_c        = s0_axis_tvalid & s0_axis_tready;
  assign xfer1_c        = s1_axis_tvalid & s1_axis_tready;
  assign load_c         = xfer0_c | xfer1_c;
  assign load_data_c    = xfer1_c ? s1_axis_tdata : s0_axis_tdata;

  // Round-robin history; s0 wins the first contest after reset
  always_ff @(posedge clk) begin
    if (rst) last_served_q <= 1'b1;
    else     last_served_q <= last_served_d;
  end

  // Remember the most recently served source
  always_comb begin
    last_served_d = last_served_q;
    if (load_c) last_served_d = xfer1_c;
  end

`ifdef UART_ARB_LINE_LOCK_EN
  localparam int unsigned CNT_W = $clog2(LOCK_TIMEOUT);

  logic             lock_active_q, lock_active_d;
  logic             lock_owner_q, lock_owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Line lock state and idle timeout counter
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_active_q <= 1'b0;
      lock_owner_q  <= 1'b0;
      cnt_q         <= '0;
    end else begin
      lock_active_q <= lock_active_d;
      lock_owner_q  <= lock_owner_d;
      cnt_q         <= cnt_d;
    end
  end

  // Lock on a non-newline byte, release on the owner's newline or on timeout
  always_comb begin
    lock_active_d = lock_active_q;
    lock_owner_d  = lock_owner_q;
    cnt_d         = cnt_q;
    if (!lock_active_q) begin
      cnt_d = '0;
      if (load_c && (load_data_c != DATA_WIDTH'(NEWLINE))) begin
        lock_active_d = 1'b1;
        lock_owner_d  = xfer1_c;
      end
    end else if (load_c) begin
      // Only the owner can transfer while locked; its transfer beats the timeout
      cnt_d = '0;
      if (load_data_c == DATA_WIDTH'(NEWLINE)) lock_active_d = 1'b0;
    end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
      lock_active_d = 1'b0;
      cnt_d         = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign lock_held_c = lock_active_q;
  assign lock_own_c  = lock_owner_q;
  assign lock_active = lock_active_q;
  assign lock_owner  = lock_owner_q;
`else
  logic [31:0] unused_lock_timeout;
  assign unused_lock_timeout = 32'(LOCK_TIMEOUT);
  assign lock_held_c = 1'b0;
  assign lock_own_c  = 1'b0;
  assign lock_active = 1'b0;
  assign lock_owner  = 1'b0;
`endif

  axis_out_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_reg (
    .clk           (clk),
    .rst           (rst),
    .load          (load_c),
    .load_data     (load_data_c),
    .acc_c         (acc_c),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready)
  );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with an output-byte scoreboard.
// Line-lock scenarios run when UART_ARB_LINE_LOCK_EN is defined.
module tb_uart_tx_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s0_axis_tdata, s1_axis_tdata, m_axis_tdata;
  logic       s0_axis_tvalid, s1_axis_tvalid;
  logic       s0_axis_tready, s1_axis_tready;
  logic       m_axis_tvalid, m_axis_tready;
  logic       lock_active, lock_owner;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .DATA_WIDTH   (8),
    .LOCK_TIMEOUT (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .s0_axis_tdata  (s0_axis_tdata),
    .s0_axis_tvalid (s0_axis_tvalid),
    .s0_axis_tready (s0_axis_tready),
    .s1_axis_tdata  (s1_axis_tdata),
    .s1_axis_tvalid (s1_axis_tvalid),
    .s1_axis_tready (s1_axis_tready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .lock_active    (lock_active),
    .lock_owner     (lock_owner)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, check grants, push the expected output byte.
  // Called just after a rising edge; returns just after the next one.
  task automatic drive(input logic v0, input logic [7:0] d0,
                       input logic v1, input logic [7:0] d1,
                       input logic mr, input logic e0, input logic e1,
                       input logic psh, input string tag);
    s0_axis_tvalid = v0; s0_axis_tdata = d0;
    s1_axis_tvalid = v1; s1_axis_tdata = d1;
    m_axis_tready  = mr;
    #1;
    check({tag, "_s0_tready"}, 32'(s0_axis_tready), 32'(e0));
    check({tag, "_s1_tready"}, 32'(s1_axis_tready), 32'(e1));
    if (psh) begin
      if (v0 && e0)      exp_q.push_back(d0);
      else if (v1 && e1) exp_q.push_back(d1);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s0_axis_tvalid = 1'b0; s1_axis_tvalid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Scoreboard: every byte the UART takes must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_unexpected: observed=%0h expected=none", m_axis_tdata);
      end else begin
        check("sb_data", 32'(m_axis_tdata), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    logic [7:0] b0, b1;
    int i0, i1;
    rst = 1'b1;
    s0_axis_tdata = 8'h00; s1_axis_tdata = 8'h00;
    s0_axis_tvalid = 1'b0; s1_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    do_reset();

    // Reset state
    check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_tdata", 32'(m_axis_tdata), 32'd0);
    check("rst_lock_active", 32'(lock_active), 32'd0);
    check("rst_lock_owner", 32'(lock_owner), 32'd0);

    // 1: s0 streams A,B,C with the UART always ready
    drive(1, "A", 0, 8'h00, 1, 1, 0, 1, "t1_a");
    check("t1_a_tvalid", 32'(m_axis_tvalid), 32'd1);
    check("t1_a_tdata", 32'(m_axis_tdata), 32'h41);
`ifdef UART_ARB_LINE_LOCK_EN
    check("t1_lock", 32'(lock_active), 32'd1);
`else
    check("t1_lock", 32'(lock_active), 32'd0);
`endif
    drive(1, "B", 0, 8'h00, 1, 1, 0, 1, "t1_b");
    check("t1_b_tdata", 32'(m_axis_tdata), 32'h42);
    drive(1, "C", 0, 8'h00, 1, 1, 0, 1, "t1_c");
    check("t1_c_tdata", 32'(m_axis_tdata), 32'h43);
    drive(0, 8'h00, 0, 8'h00, 1, 1, 0, 1, "t1_idle");
    check("t1_drained", 32'(m_axis_tvalid), 32'd0);

`ifndef UART_ARB_LINE_LOCK_EN
    // 2: both sources valid from reset alternate, s0 first
    do_reset();
    i0 = 0; i1 = 0;
    for (int k = 0; k < 6; k++) begin
      b0 = 8'(8'h10 + i0);
      b1 = 8'(8'h20 + i1);
      if (k % 2 == 0) begin
        drive(1, b0, 1, b1, 1, 1, 0, 1, $sformatf("t2_k%0d", k));
        check($sformatf("t2_k%0d_tdata", k), 32'(m_axis_tdata), 32'(b0));
        i0++;
      end else begin
        drive(1, b0, 1, b1, 1, 0, 1, 1, $sformatf("t2_k%0d", k));
        check($sformatf("t2_k%0d_tdata", k), 32'(m_axis_tdata), 32'(b1));
        i1++;
      end
    end

    // 3: backpressure holds the register full and blocks both sources
    for (int k = 0; k < 5; k++) begin
      drive(1, 8'h13, 1, 8'h23, 0, 0, 0, 1, $sformatf("t3_hold%0d", k));
      check($sformatf("t3_hold%0d_tdata", k), 32'(m_axis_tdata), 32'h22);
      check($sformatf("t3_hold%0d_tvalid", k), 32'(m_axis_tvalid), 32'd1);
    end
    drive(1, 8'h13, 1, 8'h23, 1, 1, 0, 1, "t3_release");
    check("t3_next_tdata", 32'(m_axis_tdata), 32'h13);
    check("t3_next_tvalid", 32'(m_axis_tvalid), 32'd1);
    drive(0, 8'h00, 0, 8'h00, 1, 1, 0, 1, "t3_idle");
    check("t3_drained", 32'(m_axis_tvalid), 32'd0);
`else
    // 4: s0 holds the line for "hi\n" while s1 waits
    do_reset();
    drive(1, "h", 1, 8'h55, 1, 1, 0, 1, "t4_h");
    check("t4_lock_on", 32'(lock_active), 32'd1);
    check("t4_owner", 32'(lock_owner), 32'd0);
    drive(1, "i", 1, 8'h55, 1, 1, 0, 1, "t4_i");
    drive(1, 8'h0A, 1, 8'h55, 1, 1, 0, 1, "t4_nl");
    check("t4_lock_off", 32'(lock_active), 32'd0);
    drive(0, 8'h00, 1, 8'h55, 1, 0, 1, 1, "t4_s1");
    check("t4_s1_tdata", 32'(m_axis_tdata), 32'h55);
    check("t4_s1_owner", 32'(lock_owner), 32'd1);
    drive(0, 8'h00, 1, 8'h0A, 1, 0, 1, 1, "t4_s1_nl");
    check("t4_s1_unlock", 32'(lock_active), 32'd0);
    drive(0, 8'h00, 0, 8'h00, 1, 1, 0, 1, "t4_idle");

    // 5: idle owner loses the lock after LOCK_TIMEOUT locked cycles
    drive(1, "x", 1, 8'h66, 1, 1, 0, 1, "t5_x");
    check("t5_lock_on", 32'(lock_active), 32'd1);
    for (int k = 1; k <= 8; k++) begin
      drive(0, 8'h00, 1, 8'h66, 1, 1, 0, 1, $sformatf("t5_wait%0d", k));
      check($sformatf("t5_wait%0d_lock", k), 32'(lock_active), (k < 8) ? 32'd1 : 32'd0);
    end
    drive(0, 8'h00, 1, 8'h66, 1, 0, 1, 1, "t5_s1");
    check("t5_s1_tdata", 32'(m_axis_tdata), 32'h66);
    drive(0, 8'h00, 1, 8'h0A, 1, 0, 1, 1, "t5_s1_nl");
    drive(0, 8'h00, 0, 8'h00, 1, 1, 0, 1, "t5_idle");
`endif

    // 6: reset with a byte parked in the output register
    drive(1, 8'h77, 0, 8'h00, 0, 1, 0, 0, "t6_park");
    check("t6_parked", 32'(m_axis_tvalid), 32'd1);
    rst = 1'b1;
    s0_axis_tvalid = 1'b0; s1_axis_tvalid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t6_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("t6_tdata", 32'(m_axis_tdata), 32'd0);
    check("t6_lock", 32'(lock_active), 32'd0);
    drive(1, 8'h81, 1, 8'h91, 1, 1, 0, 1, "t6_first");
    check("t6_first_tdata", 32'(m_axis_tdata), 32'h81);
    drive(0, 8'h00, 0, 8'h00, 1, 1, 0, 1, "t6_idle");

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
